// File: rtl/ps2_host_tx_if.sv
// PS/2 host transmitter bundle: byte handshake, status pulses and open-drain pin controls.
// master = system/pin side, slave = the transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       kb_clk_in;
    logic       kb_data_in;
    logic       kb_clk_oe;
    logic       kb_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data, tx_valid, kb_clk_in, kb_data_in,
        input  tx_ready, kb_clk_oe, kb_data_oe, busy, tx_done, tx_err
    );

    modport slave (
        input  tx_data, tx_valid, kb_clk_in, kb_data_in,
        output tx_ready, kb_clk_oe, kb_data_oe, busy, tx_done, tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, device-clocked shift, ACK check.
// Optional single automatic retry on error when PS2_TX_RETRY_EN is defined.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input logic          CLOCK_50,
    input logic          resetn,
    ps2_host_tx_if.slave bus
);
    localparam int MAX_CNT = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_BITS, S_ACK, S_WAIT_IDLE, S_ERROR
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
    logic                   r_clk_prev;
    logic [9:0]             r_shift;
    logic [3:0]             r_idx;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_clk_oe, r_data_oe, r_done, r_err;
    logic                   w_clk_s, w_dat_s, w_fall, w_tmo, w_inh_end;
    logic                   w_load, w_cnt_clr;
    logic                   w_clk_oe_nxt, w_data_oe_nxt, w_done_nxt, w_err_nxt;
`ifdef PS2_TX_RETRY_EN
    logic                   r_retried, w_retry;
`endif

    assign w_clk_s   = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s   = r_dat_sync[SYNC_STAGES-1];
    assign w_fall    = r_clk_prev & ~w_clk_s;
    assign w_tmo     = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_inh_end = (r_cnt == CNT_W'(INHIBIT_CYCLES - 1));

    // Shared counter: inhibit hold, then the timeout window from RTS on.
    assign w_cnt_clr = (w_state_nxt != r_state) &&
                       ((w_state_nxt == S_INHIBIT) || (w_state_nxt == S_RTS));

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
`ifdef PS2_TX_RETRY_EN
        w_retry     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.tx_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_INHIBIT;
                end
            end
            S_INHIBIT:   if (w_inh_end) w_state_nxt = S_RTS;
            S_RTS:       w_state_nxt = w_tmo ? S_ERROR : S_BITS;
            S_BITS: begin
                if (w_tmo)                       w_state_nxt = S_ERROR;
                else if (w_fall && r_idx == 4'd9) w_state_nxt = S_ACK;
            end
            S_ACK: begin
                if (w_tmo)       w_state_nxt = S_ERROR;
                else if (w_fall) w_state_nxt = w_dat_s ? S_ERROR : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (w_tmo) begin
                    w_state_nxt = S_ERROR;
                end else if (w_clk_s && w_dat_s) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_ERROR: begin
`ifdef PS2_TX_RETRY_EN
                if (!r_retried) begin
                    w_retry     = 1'b1;
                    w_state_nxt = S_INHIBIT;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`else
                w_err_nxt   = 1'b1;
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_clk_oe_nxt  = (w_state_nxt == S_INHIBIT) || (w_state_nxt == S_RTS);
        w_data_oe_nxt = 1'b0;
        if (w_state_nxt == S_RTS) begin
            w_data_oe_nxt = 1'b1;
        end else if (w_state_nxt == S_BITS) begin
            // Start bit stays low from RTS until the first device falling edge.
            if (r_state != S_BITS) w_data_oe_nxt = 1'b1;
            else if (w_fall)       w_data_oe_nxt = ~r_shift[r_idx];
            else                   w_data_oe_nxt = r_data_oe;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
            r_shift    <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], bus.kb_clk_in};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], bus.kb_data_in};
            r_clk_prev <= w_clk_s;
            r_clk_oe   <= w_clk_oe_nxt;
            r_data_oe  <= w_data_oe_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            if (w_load)
                r_shift <= {1'b1, ~^bus.tx_data, bus.tx_data};
            if (r_state == S_RTS)
                r_idx <= '0;
            else if (r_state == S_BITS && w_fall)
                r_idx <= r_idx + 4'd1;
            if (w_cnt_clr)
                r_cnt <= '0;
            else if (r_state != S_IDLE && r_state != S_ERROR)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)      r_retried <= 1'b0;
        else if (w_load)  r_retried <= 1'b0;
        else if (w_retry) r_retried <= 1'b1;
    end
`endif

    assign bus.tx_ready   = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.kb_clk_oe  = r_clk_oe;
    assign bus.kb_data_oe = r_data_oe;
    assign bus.tx_done    = r_done;
    assign bus.tx_err     = r_err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int TMO  = 400;
  localparam int HALF = 8;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;
  int checks = 0, failures = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;

  ps2_host_tx_if bus();

  assign bus.kb_clk_in  = dev_clk  & ~bus.kb_clk_oe;
  assign bus.kb_data_in = dev_data & ~bus.kb_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (bus.tx_done) done_cnt++;
    if (bus.tx_err) err_cnt++;
    if (bus.tx_done && bus.tx_err) both_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_req(input logic [7:0] d);
    @(negedge CLOCK_50);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge CLOCK_50);
    bus.tx_valid = 1'b0;
  endtask

  // Waits for the host to release the clock with the start bit low, then clocks nedges falling edges.
  // Line data is sampled just before each falling edge; slot 10 is the stop bit, then ACK is driven.
  task automatic device_frame(input int nedges, input bit ack_low,
                              output logic [10:0] bits, output bit ok);
    int n;
    bits = '0;
    ok   = 1'b0;
    n    = 0;
    while (!(bus.kb_data_oe && !bus.kb_clk_oe) && n < 2*INH + 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!(bus.kb_data_oe && !bus.kb_clk_oe)) return;
    ok = 1'b1;
    for (int e = 1; e <= nedges; e++) begin
      repeat (HALF) @(negedge CLOCK_50);
      bits[e-1] = bus.kb_data_in;
      if (e == 11 && ack_low) dev_data = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk = 1'b1;
    end
    if (nedges == 11) begin
      repeat (HALF) @(negedge CLOCK_50);
      dev_data = 1'b1;
    end
  endtask

  task automatic run_byte(input logic [7:0] d, input logic [10:0] exp_bits, input string tag);
    logic [10:0] bits;
    bit ok;
    int bd, be;
    bd = done_cnt;
    be = err_cnt;
    send_req(d);
    device_frame(11, 1'b1, bits, ok);
    check({tag, "_frame_seen"}, ok, 1);
    check({tag, "_bits"}, bits, exp_bits);
    repeat (30) @(negedge CLOCK_50);
    check({tag, "_done"}, done_cnt - bd, 1);
    check({tag, "_err"}, err_cnt - be, 0);
    check({tag, "_ready"}, bus.tx_ready, 1);
  endtask

  initial begin
    logic [10:0] bits;
    bit ok;
    int n, bd, be, lat;

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_ready", bus.tx_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_lines", {bus.kb_clk_oe, bus.kb_data_oe}, 2'b00);
    check("rst_pulses", {bus.tx_done, bus.tx_err}, 2'b00);
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    check("idle_ready", bus.tx_ready, 1);

    // 0xED: latency to start bit, inhibit outputs, then full frame with parity 1
    bd = done_cnt;
    @(negedge CLOCK_50);
    bus.tx_data  = 8'hED;
    bus.tx_valid = 1'b1;
    @(posedge CLOCK_50);
    n = 1;
    #1;
    bus.tx_valid = 1'b0;
    check("inh_clk_oe", bus.kb_clk_oe, 1);
    check("inh_data_oe", bus.kb_data_oe, 0);
    check("inh_busy_ready", {bus.busy, bus.tx_ready}, 2'b10);
    while (!bus.kb_data_oe && n < 4*INH) begin
      @(posedge CLOCK_50);
      n++;
      #1;
    end
    lat = n;
    check("start_latency", lat, INH + 1);
    device_frame(11, 1'b1, bits, ok);
    check("ed_frame_seen", ok, 1);
    check("ed_bits", bits, 11'h7DA);
    repeat (30) @(negedge CLOCK_50);
    check("ed_done", done_cnt - bd, 1);
    check("ed_lines", {bus.kb_clk_oe, bus.kb_data_oe}, 2'b00);

    run_byte(8'hF4, 11'h5E8, "f4");
    run_byte(8'h00, 11'h600, "z0");

    // tx_valid held with new data while busy: ignored until IDLE
    bd = done_cnt;
    @(negedge CLOCK_50);
    bus.tx_data  = 8'hED;
    bus.tx_valid = 1'b1;
    @(negedge CLOCK_50);
    bus.tx_data  = 8'hFF;
    device_frame(11, 1'b1, bits, ok);
    check("hold_bits", bits, 11'h7DA);
    n = 0;
    while (done_cnt == bd && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("hold_first_done", done_cnt - bd, 1);
    n = 0;
    while (!bus.busy && n < 10) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("hold_reaccept", bus.busy, 1);
    bus.tx_valid = 1'b0;
    device_frame(11, 1'b1, bits, ok);
    check("ff_bits", bits, 11'h7FE);
    repeat (30) @(negedge CLOCK_50);
    check("ff_done", done_cnt - bd, 2);

    // reset after bit 3 has been presented
    bd = done_cnt;
    be = err_cnt;
    send_req(8'h3C);
    device_frame(4, 1'b1, bits, ok);
    repeat (4) @(negedge CLOCK_50);
    check("mid_busy", bus.busy, 1);
    @(negedge CLOCK_50);
    resetn = 1'b0;
    #1;
    check("mid_rst_lines", {bus.kb_clk_oe, bus.kb_data_oe}, 2'b00);
    check("mid_rst_ready", bus.tx_ready, 1);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("mid_rst_no_pulse", (done_cnt - bd) + (err_cnt - be), 0);
    check("mid_rst_idle", {bus.tx_ready, bus.busy}, 2'b10);

    // device NACK (data high at ACK slot); 0xA5 has parity 1
    bd = done_cnt;
    be = err_cnt;
    send_req(8'hA5);
    device_frame(11, 1'b0, bits, ok);
    check("nack_bits", bits, 11'h74A);
`ifdef PS2_TX_RETRY_EN
    repeat (5) @(negedge CLOCK_50);
    check("retry_no_err", err_cnt - be, 0);
    check("retry_busy", bus.busy, 1);
    device_frame(11, 1'b1, bits, ok);
    check("retry_second_inhibit", ok, 1);
    check("retry_bits", bits, 11'h74A);
    repeat (30) @(negedge CLOCK_50);
    check("retry_done", done_cnt - bd, 1);
    check("retry_err", err_cnt - be, 0);
`else
    repeat (30) @(negedge CLOCK_50);
    check("nack_err", err_cnt - be, 1);
    check("nack_done", done_cnt - bd, 0);
    check("nack_ready", bus.tx_ready, 1);
`endif

    // device never clocks: timeout from RTS
    bd = done_cnt;
    be = err_cnt;
    send_req(8'h55);
    n = 0;
    while (!bus.kb_data_oe && n < 4*INH) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("tmo_rts_seen", bus.kb_data_oe, 1);
    n = 0;
    while (err_cnt == be && n < 3*TMO + 2*INH) begin
      @(negedge CLOCK_50);
      n++;
    end
`ifdef PS2_TX_RETRY_EN
    check("tmo_latency_range", (n >= 2*TMO + INH + 1) && (n <= 2*TMO + INH + 3), 1);
`else
    check("tmo_latency_range", (n >= TMO) && (n <= TMO + 2), 1);
`endif
    check("tmo_err", err_cnt - be, 1);
    check("tmo_lines", {bus.kb_clk_oe, bus.kb_data_oe}, 2'b00);
    check("tmo_ready", bus.tx_ready, 1);
    check("tmo_no_done", done_cnt - bd, 0);

    check("never_both", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
